// File: rtl/mux21_arbiter_if.sv
// rtl/mux21_arbiter_if.sv - request/data/handshake bundle between two packet sources, the arbiter and one consumer
interface mux21_arbiter_if #(
    parameter int W = 8
);
    logic         req0;
    logic [W-1:0] d0;
    logic         last0;
    logic         ack0;
    logic         req1;
    logic [W-1:0] d1;
    logic         last1;
    logic         ack1;
    logic         s1;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         busy;

    modport master (
        input  req0, d0, last0, req1, d1, last1, y_ready,
        output ack0, ack1, s1, y, y_valid, busy
    );

    modport slave (
        output req0, d0, last0, req1, d1, last1, y_ready,
        input  ack0, ack1, s1, y, y_valid, busy
    );
endinterface

// File: rtl/mux21_arbiter.sv
// rtl/mux21_arbiter.sv - packet-locked round-robin arbiter driving a shared 2-1 mux and a one-entry output register
// Optional feature: MUX21_ARB_BURST_LIMIT_EN caps a grant at MAXBURST beats while the other requester waits.
module mux21_arbiter #(
    parameter int W        = 8,
    parameter int MAXBURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux21_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic [W-1:0] y_q, y_d;
    logic         y_valid_q, y_valid_d;

    logic out_free;
    logic acc0, acc1, accept;
    logic brk0, brk1;
    logic rel0, rel1;

    // The output slot is free when empty or being drained this cycle.
    assign out_free = ~y_valid_q | bus.y_ready;
    assign bus.ack0 = (state_q == GRANT0) & out_free;
    assign bus.ack1 = (state_q == GRANT1) & out_free;
    assign acc0     = bus.req0 & bus.ack0;
    assign acc1     = bus.req1 & bus.ack1;
    assign accept   = acc0 | acc1;

    assign bus.s1      = (state_q == GRANT1);
    assign bus.busy    = (state_q != IDLE);
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;

`ifdef MUX21_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAXBURST) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_hit;

    // Once the limit is reached (or held saturated) the next accept may yield the grant.
    assign cnt_hit = (cnt_q >= CW'(MAXBURST - 1));
    assign brk0    = acc0 & cnt_hit & bus.req1;
    assign brk1    = acc1 & cnt_hit & bus.req0;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != CW'(MAXBURST))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_maxburst = MAXBURST;

    assign brk0 = 1'b0;
    assign brk1 = 1'b0;
`endif

    assign rel0 = acc0 & (bus.last0 | brk0);
    assign rel1 = acc1 & (bus.last1 | brk1);

    // prio_q names the requester that wins the next IDLE tie.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && (!bus.req1 || !prio_q)) begin
                    state_d = GRANT0;
                end else if (bus.req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (rel0) begin
                    prio_d  = 1'b1;
                    state_d = bus.req1 ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (rel1) begin
                    prio_d  = 1'b0;
                    state_d = bus.req0 ? GRANT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (accept) begin
            y_d       = bus.s1 ? bus.d1 : bus.d0;
            y_valid_d = 1'b1;
        end else if (bus.y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end
endmodule

// File: tb/tb_mux21_arbiter.sv
// tb/tb_mux21_arbiter.sv - directed self-checking bench for mux21_arbiter
module tb_mux21_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mux21_arbiter_if #(.W(8)) bus ();

    mux21_arbiter #(.W(8), .MAXBURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0    = 1'b0;
        bus.d0      = 8'h00;
        bus.last0   = 1'b0;
        bus.req1    = 1'b0;
        bus.d1      = 8'h00;
        bus.last1   = 1'b0;
        bus.y_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Reset state
        do_reset();
        #3;
        check("rst_s1", bus.s1, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_y_valid", bus.y_valid, 1'b0);
        check("rst_y", bus.y, 8'h00);
        check("rst_ack0", bus.ack0, 1'b0);
        check("rst_ack1", bus.ack1, 1'b0);

        // Test 1: reset mid-packet from GRANT1 with a full output stage
        do_reset();
        bus.req1 = 1'b1;
        bus.d1   = 8'hA5;
        cyc();
        cyc();
        #3;
        check("t1_pre_s1", bus.s1, 1'b1);
        check("t1_pre_y_valid", bus.y_valid, 1'b1);
        check("t1_pre_y", bus.y, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("t1_rst_s1", bus.s1, 1'b0);
        check("t1_rst_y_valid", bus.y_valid, 1'b0);
        check("t1_rst_busy", bus.busy, 1'b0);
        check("t1_rst_y", bus.y, 8'h00);

        // Test 3 continues from this reset: both requesters, 1-beat packets
        bus.req0    = 1'b1;
        bus.d0      = 8'h0A;
        bus.last0   = 1'b1;
        bus.req1    = 1'b1;
        bus.d1      = 8'h1B;
        bus.last1   = 1'b1;
        bus.y_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("t3_idle_busy", bus.busy, 1'b0);
        check("t3_idle_ack0", bus.ack0, 1'b0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            #3;
            check($sformatf("t3_s1_%0d", i), bus.s1, (i % 2 == 1));
            check($sformatf("t3_busy_%0d", i), bus.busy, 1'b1);
            check($sformatf("t3_ack0_%0d", i), bus.ack0, (i % 2 == 0));
            if (i > 0) begin
                check($sformatf("t3_y_%0d", i), bus.y, (i % 2 == 1) ? 8'h0A : 8'h1B);
                check($sformatf("t3_yv_%0d", i), bus.y_valid, 1'b1);
            end
            cyc();
        end

        // Test 2: requester 0 alone, 3-beat packet
        do_reset();
        bus.req0    = 1'b1;
        bus.d0      = 8'h11;
        bus.y_ready = 1'b1;
        #3;
        check("t2_c1_ack0", bus.ack0, 1'b0);
        check("t2_c1_busy", bus.busy, 1'b0);
        cyc();
        #3;
        check("t2_c2_ack0", bus.ack0, 1'b1);
        cyc();
        bus.d0 = 8'h22;
        #3;
        check("t2_c3_y", bus.y, 8'h11);
        check("t2_c3_ack0", bus.ack0, 1'b1);
        cyc();
        bus.d0    = 8'h33;
        bus.last0 = 1'b1;
        #3;
        check("t2_c4_y", bus.y, 8'h22);
        check("t2_c4_ack0", bus.ack0, 1'b1);
        cyc();
        bus.last0 = 1'b0;
        bus.d1    = 8'hC3;
        bus.req1  = 1'b1;
        #3;
        check("t2_c5_y", bus.y, 8'h33);
        check("t2_c5_y_valid", bus.y_valid, 1'b1);
        check("t2_c5_busy", bus.busy, 1'b0);
        // Tie in IDLE after requester 0 was served goes to requester 1
        cyc();
        #3;
        check("t2_tie_s1", bus.s1, 1'b1);

        // Test 4: backpressure
        do_reset();
        bus.req0 = 1'b1;
        bus.d0   = 8'h41;
        cyc();
        #3;
        check("t4_c2_ack0", bus.ack0, 1'b1);
        cyc();
        bus.d0 = 8'h42;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("t4_hold_y_%0d", i), bus.y, 8'h41);
            check($sformatf("t4_hold_yv_%0d", i), bus.y_valid, 1'b1);
            check($sformatf("t4_hold_ack0_%0d", i), bus.ack0, 1'b0);
            cyc();
        end
        bus.y_ready = 1'b1;
        bus.last0   = 1'b1;
        #3;
        check("t4_c6_ack0", bus.ack0, 1'b1);
        check("t4_c6_y", bus.y, 8'h41);
        cyc();
        bus.req0  = 1'b0;
        bus.last0 = 1'b0;
        #3;
        check("t4_c7_y", bus.y, 8'h42);
        check("t4_c7_y_valid", bus.y_valid, 1'b1);
        check("t4_c7_busy", bus.busy, 1'b0);
        cyc();
        #3;
        check("t4_c8_y_valid", bus.y_valid, 1'b0);
        check("t4_c8_y", bus.y, 8'h42);

        // Test 5: requester 1 raised mid packet
        do_reset();
        bus.req0    = 1'b1;
        bus.d0      = 8'h51;
        bus.y_ready = 1'b1;
        bus.d1      = 8'h77;
        bus.last1   = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            bus.d0    = 8'h51 + 8'(k);
            bus.last0 = (k == 4);
            bus.req1  = (k >= 1);
            #3;
            check($sformatf("t5_s1_%0d", k), bus.s1, 1'b0);
            check($sformatf("t5_ack1_%0d", k), bus.ack1, 1'b0);
            if (k > 0) begin
                check($sformatf("t5_y_%0d", k), bus.y, 8'h51 + 8'(k - 1));
            end
            cyc();
        end
        bus.req0  = 1'b0;
        bus.last0 = 1'b0;
        #3;
        check("t5_switch_s1", bus.s1, 1'b1);
        check("t5_switch_ack1", bus.ack1, 1'b1);
        check("t5_last_y", bus.y, 8'h55);
        cyc();
        bus.req1 = 1'b0;
        #3;
        check("t5_y1", bus.y, 8'h77);

`ifdef MUX21_ARB_BURST_LIMIT_EN
        // Test 6: 6-beat packet split after 4 beats while requester 1 waits
        begin
            logic [7:0] exp_y [2:9];
            logic       exp_s1[2:9];
            exp_y  = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h65, 8'h66};
            exp_s1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            do_reset();
            bus.req0    = 1'b1;
            bus.req1    = 1'b1;
            bus.d0      = 8'h61;
            bus.d1      = 8'h71;
            bus.last1   = 1'b1;
            bus.y_ready = 1'b1;
            cyc();
            for (int c = 2; c <= 9; c++) begin
                case (c)
                    2, 3, 4, 5: bus.d0 = 8'h61 + 8'(c - 2);
                    6:          bus.d0 = 8'h65;
                    7:          begin bus.d0 = 8'h65; bus.req1 = 1'b0; end
                    8:          begin bus.d0 = 8'h66; bus.last0 = 1'b1; end
                    default:    begin bus.req0 = 1'b0; bus.last0 = 1'b0; end
                endcase
                #3;
                if (c <= 8) begin
                    check($sformatf("t6_s1_c%0d", c), bus.s1, exp_s1[c]);
                end
                if (c >= 3) begin
                    check($sformatf("t6_y_c%0d", c), bus.y, exp_y[c]);
                end
                cyc();
            end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
